// File: rtl/ripple_adder_pkg.sv
// ----------------------------------------------------------------------------
// ripple_adder_pkg
//
// Shared definitions for the ripple-carry adder and its users.
//   RIPPLE_ADDER_DEFAULT_WIDTH : default operand / sum width
//   ripple_adder_ext_t         : {cout, sum} extended result at the default
//                                width, handy for reference arithmetic
// ----------------------------------------------------------------------------
package ripple_adder_pkg;

    localparam int RIPPLE_ADDER_DEFAULT_WIDTH = 4;

    typedef logic [RIPPLE_ADDER_DEFAULT_WIDTH:0] ripple_adder_ext_t;

endpackage : ripple_adder_pkg

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
//
// Single-bit combinational full adder, the cell the ripple chain is built of.
// Ports:
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit      = a ^ b ^ ci
//   co   : carry out    = majority(a, b, ci)
// ----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder

// File: rtl/ripple_adder.sv
// ----------------------------------------------------------------------------
// ripple_adder
//
// Parameterised ripple-carry adder with a combinational result and a
// registered copy one clock later. The carry chain is an explicit string of
// full_adder cells so the ripple structure survives synthesis.
//
// Parameters:
//   WIDTH  : operand / sum width (>= 1)
//
// Ports:
//   clk    : rising-edge clock for the output register stage
//   rst_n  : asynchronous active-low reset (clears registered outputs only)
//   a, b   : operands (unsigned or two's complement)
//   cin    : carry into bit 0
//   s      : combinational sum, (a + b + cin) mod 2^WIDTH
//   cout   : combinational carry out of bit WIDTH-1
//   s_q    : registered s
//   cout_q : registered cout
//   ovf    : combinational signed overflow   (RIPPLE_ADDER_OVF_EN only)
//   ovf_q  : registered ovf                  (RIPPLE_ADDER_OVF_EN only)
//
// Build option:
//   RIPPLE_ADDER_OVF_EN : when defined, adds the ovf / ovf_q ports and logic.
// ----------------------------------------------------------------------------
module ripple_adder
    import ripple_adder_pkg::*;
#(
    parameter int WIDTH = RIPPLE_ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q
`ifdef RIPPLE_ADDER_OVF_EN
    ,
    output logic             ovf,
    output logic             ovf_q
`endif
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
        full_adder u_fa (
            .a  (a[gi]),
            .b  (b[gi]),
            .ci (c[gi]),
            .s  (s[gi]),
            .co (c[gi+1])
        );
    end

    assign cout = c[WIDTH];

    // Next-state values of the register stage: a straight copy of the
    // combinational result, captured every edge (no enable).
    logic [WIDTH-1:0] s_d;
    logic             cout_d;

    assign s_d    = s;
    assign cout_d = cout;

`ifdef RIPPLE_ADDER_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    // With WIDTH == 1 the carry into the sign bit is cin itself.
    logic ovf_d;

    assign ovf   = c[WIDTH] ^ c[WIDTH-1];
    assign ovf_d = ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
`ifdef RIPPLE_ADDER_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
`ifdef RIPPLE_ADDER_OVF_EN
            ovf_q  <= ovf_d;
`endif
        end
    end

endmodule : ripple_adder

// File: tb/tb_ripple_adder.sv
module tb_ripple_adder;
    import ripple_adder_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic [W-1:0] s_q;
    logic         cout_q;
`ifdef RIPPLE_ADDER_OVF_EN
    logic         ovf;
    logic         ovf_q;
`endif

    int n_checks;
    int n_pass;

    ripple_adder #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .s      (s),
        .cout   (cout),
        .s_q    (s_q),
        .cout_q (cout_q)
`ifdef RIPPLE_ADDER_OVF_EN
        ,
        .ovf    (ovf),
        .ovf_q  (ovf_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition, truncated to W+1 bits.
    function automatic ripple_adder_ext_t ref_add(input logic [W-1:0] x,
                                                  input logic [W-1:0] y,
                                                  input logic ci);
        int t;
        t = int'(x) + int'(y) + int'(ci);
        return t[W:0];
    endfunction

    // Reference: signed overflow from the true signed sum's range.
    function automatic logic ref_ovf(input logic [W-1:0] x,
                                     input logic [W-1:0] y,
                                     input logic ci);
        int sx;
        int sy;
        int t;
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        t  = sx + sy + int'(ci);
        return (t > (1 << (W-1)) - 1) || (t < -(1 << (W-1)));
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a     = 4'hF;
        b     = 4'hF;
        cin   = 1'b1;
        #3;
        n_checks++;
        if (s_q !== 4'h0 || cout_q !== 1'b0)
            $display("FAIL reset_init: s_q=%h cout_q=%b, want 0/0", s_q, cout_q);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (s_q !== 4'h0 || cout_q !== 1'b0)
            $display("FAIL reset_hold: s_q=%h cout_q=%b, want 0/0", s_q, cout_q);
        else n_pass++;
`ifdef RIPPLE_ADDER_OVF_EN
        n_checks++;
        if (ovf_q !== 1'b0)
            $display("FAIL reset_ovf_q: ovf_q=%b, want 0", ovf_q);
        else n_pass++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{4'b0000, 4'b0001, 4'b0101, 4'b1111, 4'b1010};
        logic [W-1:0] tb [5] = '{4'b0000, 4'b0010, 4'b0011, 4'b0001, 4'b0101};
        logic         tc [5] = '{1'b0,    1'b0,    1'b1,    1'b0,    1'b1};
        logic [W-1:0] es [5] = '{4'b0000, 4'b0011, 4'b1001, 4'b0000, 4'b0000};
        logic         ec [5] = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b1};
        logic         eo [5] = '{1'b0,    1'b0,    1'b1,    1'b0,    1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a   = ta[i];
            b   = tb[i];
            cin = tc[i];
            #1;
            n_checks++;
            if (s !== es[i] || cout !== ec[i])
                $display("FAIL directed_comb[%0d]: s=%b cout=%b, want s=%b cout=%b",
                         i, s, cout, es[i], ec[i]);
            else n_pass++;
`ifdef RIPPLE_ADDER_OVF_EN
            n_checks++;
            if (ovf !== eo[i])
                $display("FAIL directed_ovf[%0d]: ovf=%b, want %b", i, ovf, eo[i]);
            else n_pass++;
`else
            if (eo[i] !== ref_ovf(ta[i], tb[i], tc[i]))
                $display("note: directed table ovf entry %0d disagrees with model", i);
`endif
            @(posedge clk);
            #1;
            n_checks++;
            if (s_q !== es[i] || cout_q !== ec[i])
                $display("FAIL directed_reg[%0d]: s_q=%b cout_q=%b, want s_q=%b cout_q=%b",
                         i, s_q, cout_q, es[i], ec[i]);
            else n_pass++;
`ifdef RIPPLE_ADDER_OVF_EN
            n_checks++;
            if (ovf_q !== eo[i])
                $display("FAIL directed_ovf_q[%0d]: ovf_q=%b, want %b", i, ovf_q, eo[i]);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_reset_latency();
        @(negedge clk);
        a   = 4'b1111;
        b   = 4'b1111;
        cin = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (s_q !== 4'b1111 || cout_q !== 1'b1)
            $display("FAIL rl_load: s_q=%b cout_q=%b, want 1111/1", s_q, cout_q);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (s_q !== 4'b0000 || cout_q !== 1'b0)
            $display("FAIL rl_async_clear: s_q=%b cout_q=%b, want 0000/0", s_q, cout_q);
        else n_pass++;
        n_checks++;
        if (s !== 4'b1111 || cout !== 1'b1)
            $display("FAIL rl_comb_in_reset: s=%b cout=%b, want 1111/1", s, cout);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (s_q !== 4'b0000)
            $display("FAIL rl_after_release: s_q=%b, want 0000", s_q);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (s_q !== 4'b1111 || cout_q !== 1'b1)
            $display("FAIL rl_reload: s_q=%b cout_q=%b, want 1111/1", s_q, cout_q);
        else n_pass++;
    endtask

    task automatic test_exhaustive();
        ripple_adder_ext_t e;
        int errs;
        errs = 0;
        for (int v = 0; v < 512; v++) begin
            @(negedge clk);
            a   = v[3:0];
            b   = v[7:4];
            cin = v[8];
            e   = ref_add(a, b, cin);
            #1;
            n_checks++;
            if ({cout, s} !== e) begin
                errs++;
                if (errs < 10)
                    $display("FAIL sweep_comb: a=%h b=%h cin=%b got %b_%b, want %b",
                             a, b, cin, cout, s, e);
            end else n_pass++;
`ifdef RIPPLE_ADDER_OVF_EN
            n_checks++;
            if (ovf !== ref_ovf(a, b, cin))
                $display("FAIL sweep_ovf: a=%h b=%h cin=%b ovf=%b", a, b, cin, ovf);
            else n_pass++;
`endif
            @(posedge clk);
            #1;
            n_checks++;
            if ({cout_q, s_q} !== e) begin
                errs++;
                if (errs < 10)
                    $display("FAIL sweep_reg: a=%h b=%h cin=%b got %b_%b, want %b",
                             a, b, cin, cout_q, s_q, e);
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        ripple_adder_ext_t e1;
        ripple_adder_ext_t e2;
        logic [W-1:0] a2;
        logic [W-1:0] b2;
        logic         c2;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            a   = W'($urandom_range(15));
            b   = W'($urandom_range(15));
            cin = 1'($urandom_range(1));
            e1  = ref_add(a, b, cin);
            @(posedge clk);
            #1;
            n_checks++;
            if ({cout_q, s_q} !== e1)
                $display("FAIL b2b_capture[%0d]: got %b_%b, want %b", i, cout_q, s_q, e1);
            else n_pass++;
            // Change inputs between edges: only the combinational side moves.
            a2 = W'($urandom_range(15));
            b2 = W'($urandom_range(15));
            c2 = 1'($urandom_range(1));
            a   = a2;
            b   = b2;
            cin = c2;
            e2  = ref_add(a2, b2, c2);
            #2;
            n_checks++;
            if ({cout, s} !== e2 || {cout_q, s_q} !== e1)
                $display("FAIL b2b_hold[%0d]: comb %b_%b want %b, reg %b_%b want %b",
                         i, cout, s, e2, cout_q, s_q, e1);
            else n_pass++;
            @(posedge clk);
            #1;
            n_checks++;
            if ({cout_q, s_q} !== e2)
                $display("FAIL b2b_next[%0d]: got %b_%b, want %b", i, cout_q, s_q, e2);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_directed();
        test_reset_latency();
        test_exhaustive();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule : tb_ripple_adder
